// File: rtl/pixel_mixer_pkg.sv
// Shared types and constants for the pixel mixer.
//   pixel_t        : {palette[5:0], color[3:0]}; color 0 is transparent
//   sprite_pixel_t : {prio[1:0], pixel_t}
//   ST_*           : mixer FSM state encodings
//   SPR_PRIO_*     : sprite priority levels relative to the tile layers
//   EN_*           : bit positions in the latched layer-enable vector
package pixel_mixer_pkg;

    localparam int ROW_WIDTH_DEF = 320;
    localparam int ADDR_W_DEF    = 9;
    localparam int PIX_W         = 10;

    typedef struct packed {
        logic [5:0] palette;
        logic [3:0] color;
    } pixel_t;

    typedef struct packed {
        logic [1:0] prio;
        pixel_t     pix;
    } sprite_pixel_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_MIX   = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    // Sprite priorities: LOW sits below bgte, MID between bgte and fgte,
    // HIGH (and above) over everything.
    localparam logic [1:0] SPR_PRIO_LOW  = 2'd0;
    localparam logic [1:0] SPR_PRIO_MID  = 2'd1;
    localparam logic [1:0] SPR_PRIO_HIGH = 2'd2;

    localparam int EN_BG  = 0;
    localparam int EN_FG  = 1;
    localparam int EN_SPR = 2;

    function automatic logic is_opaque(input pixel_t p, input logic en);
        return en && (p.color != 4'd0);
    endfunction

endpackage

// File: rtl/pixel_mixer_if.sv
// Pixel mixer bus: shared read address into the engine row buffers, the
// engine read data (1-cycle latency), and the row RAM write port.
//   master : pixel mixer (drives pixel_addr and the row RAM write port)
//   slave  : engines / row RAM (drive the layer pixels)
interface pixel_mixer_if #(
    parameter int ADDR_W = 9,
    parameter int PIX_W  = 10
);
    logic [ADDR_W-1:0] pixel_addr;
    logic [PIX_W-1:0]  bgte_pixel;
    logic [PIX_W-1:0]  fgte_pixel;
    logic [PIX_W+1:0]  spre_pixel;
    logic [PIX_W-1:0]  rowram_wrdata;
    logic [ADDR_W-1:0] rowram_wraddr;
    logic              rowram_wren;

    modport master (
        output pixel_addr,
        input  bgte_pixel, fgte_pixel, spre_pixel,
        output rowram_wrdata, rowram_wraddr, rowram_wren
    );

    modport slave (
        input  pixel_addr,
        output bgte_pixel, fgte_pixel, spre_pixel,
        input  rowram_wrdata, rowram_wraddr, rowram_wren
    );
endinterface

// File: rtl/pixel_mixer_sel.sv
// Combinational layer resolver: picks the highest-priority opaque pixel.
//   bg_i, fg_i : tile layer pixels
//   spr_i      : sprite pixel with its priority
//   en_i       : latched layer enables, indexed by EN_BG/EN_FG/EN_SPR
//   pix_o      : resolved palette reference (backdrop 0 when all transparent)
module pixel_mix_sel
    import pixel_mixer_pkg::*;
(
    input  pixel_t        bg_i,
    input  pixel_t        fg_i,
    input  sprite_pixel_t spr_i,
    input  logic [2:0]    en_i,
    output pixel_t        pix_o
);
    logic bg_op, fg_op, spr_op;

    assign bg_op  = is_opaque(bg_i, en_i[EN_BG]);
    assign fg_op  = is_opaque(fg_i, en_i[EN_FG]);
    assign spr_op = is_opaque(spr_i.pix, en_i[EN_SPR]);

    always_comb begin
        pix_o = '0;
        if (spr_op && spr_i.prio >= SPR_PRIO_HIGH)
            pix_o = spr_i.pix;
        else if (fg_op)
            pix_o = fg_i;
        else if (spr_op && spr_i.prio == SPR_PRIO_MID)
            pix_o = spr_i.pix;
        else if (bg_op)
            pix_o = bg_i;
        else if (spr_op)
            pix_o = spr_i.pix;
    end
endmodule

// File: rtl/pixel_mixer.sv
// Final composition stage: waits for the enabled engines to finish their row
// buffers, sweeps pixel_addr over the row, resolves each pixel and writes it
// into the row RAM.
//   clk, rst          : clock, synchronous active-high reset
//   prep              : start composing the next row
//   *_en, *_done      : layer enables and row-buffer-complete levels
//   bus (master)      : pixel_addr out, layer pixels in, row RAM write out
//   busy              : FSM not idle
//   row_done          : pulse the cycle after the last write of a row
//   overrun           : pulse the cycle after a prep that cut a row short
module pixel_mixer
    import pixel_mixer_pkg::*;
#(
    parameter int ROW_WIDTH = ROW_WIDTH_DEF,
    parameter int ADDR_W    = ADDR_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          prep,
    input  logic          bgte_en,
    input  logic          fgte_en,
    input  logic          spre_en,
    input  logic          bgte_done,
    input  logic          fgte_done,
    input  logic          spre_done,
    pixel_mixer_if.master bus,
    output logic          busy,
    output logic          row_done,
    output logic          overrun
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROW_WIDTH - 1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pixel_addr_q, pixel_addr_d;   // doubles as the sweep counter
    logic [2:0]        en_q, en_d;
    logic              v1_q, v1_d;                   // engine data valid this cycle
    logic [ADDR_W-1:0] a1_q, a1_d;
    logic              wren_q, wren_d;
    logic [ADDR_W-1:0] wraddr_q, wraddr_d;
    pixel_t            wrdata_q, wrdata_d;
    logic              row_done_q, row_done_d;
    logic              overrun_q, overrun_d;

    logic   deps_ready;
    pixel_t mixed;

    assign deps_ready = (bgte_done | ~bgte_en) &
                        (fgte_done | ~fgte_en) &
                        (spre_done | ~spre_en);

    pixel_mix_sel u_sel (
        .bg_i  (pixel_t'(bus.bgte_pixel)),
        .fg_i  (pixel_t'(bus.fgte_pixel)),
        .spr_i (sprite_pixel_t'(bus.spre_pixel)),
        .en_i  (en_q),
        .pix_o (mixed)
    );

    always_comb begin
        state_d      = state_q;
        pixel_addr_d = pixel_addr_q;
        en_d         = en_q;
        v1_d         = 1'b0;
        a1_d         = pixel_addr_q;
        wren_d       = v1_q;
        wraddr_d     = v1_q ? a1_q : wraddr_q;
        wrdata_d     = v1_q ? mixed : wrdata_q;
        row_done_d   = 1'b0;
        overrun_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (prep)
                    state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (prep) begin
                    overrun_d = 1'b1;
                    wren_d    = 1'b0;
                end else if (deps_ready) begin
                    state_d      = ST_MIX;
                    pixel_addr_d = '0;
                    en_d         = {spre_en, fgte_en, bgte_en};
                end
            end
            ST_MIX: begin
                if (prep) begin
                    // Both in-flight addresses are dropped: the one just
                    // issued (v1_d stays 0) and the one whose data is arriving.
                    overrun_d = 1'b1;
                    wren_d    = 1'b0;
                    state_d   = ST_WAIT;
                end else begin
                    v1_d = 1'b1;
                    if (pixel_addr_q == LAST_ADDR)
                        state_d = ST_DRAIN;
                    else
                        pixel_addr_d = pixel_addr_q + ADDR_W'(1);
                end
            end
            ST_DRAIN: begin
                // With v1_q low the final write is on the bus this cycle, so
                // a coinciding prep is a clean back-to-back start.
                if (!v1_q) begin
                    row_done_d = 1'b1;
                    state_d    = prep ? ST_WAIT : ST_IDLE;
                end else if (prep) begin
                    overrun_d = 1'b1;
                    wren_d    = 1'b0;
                    state_d   = ST_WAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pixel_addr_q <= '0;
            en_q         <= '0;
            v1_q         <= 1'b0;
            a1_q         <= '0;
            wren_q       <= 1'b0;
            wraddr_q     <= '0;
            wrdata_q     <= '0;
            row_done_q   <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pixel_addr_q <= pixel_addr_d;
            en_q         <= en_d;
            v1_q         <= v1_d;
            a1_q         <= a1_d;
            wren_q       <= wren_d;
            wraddr_q     <= wraddr_d;
            wrdata_q     <= wrdata_d;
            row_done_q   <= row_done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.pixel_addr    = pixel_addr_q;
    assign bus.rowram_wren   = wren_q;
    assign bus.rowram_wraddr = wraddr_q;
    assign bus.rowram_wrdata = wrdata_q;
    assign busy              = (state_q != ST_IDLE);
    assign row_done          = row_done_q;
    assign overrun           = overrun_q;
endmodule

// File: tb/tb_pixel_mixer.sv
module tb_pixel_mixer;

    localparam int W = 320;

    logic clk = 1'b0;
    logic rst, prep;
    logic bgte_en, fgte_en, spre_en;
    logic bgte_done, fgte_done, spre_done;
    logic busy, row_done, overrun;

    pixel_mixer_if #(.ADDR_W(9), .PIX_W(10)) bus ();

    pixel_mixer #(.ROW_WIDTH(W), .ADDR_W(9)) dut (
        .clk       (clk),
        .rst       (rst),
        .prep      (prep),
        .bgte_en   (bgte_en),
        .fgte_en   (fgte_en),
        .spre_en   (spre_en),
        .bgte_done (bgte_done),
        .fgte_done (fgte_done),
        .spre_done (spre_done),
        .bus       (bus),
        .busy      (busy),
        .row_done  (row_done),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Engine row buffers with 1-cycle read latency.
    logic [9:0]  bg_mem [0:511];
    logic [9:0]  fg_mem [0:511];
    logic [11:0] sp_mem [0:511];

    always @(posedge clk) begin
        bus.bgte_pixel <= bg_mem[bus.pixel_addr];
        bus.fgte_pixel <= fg_mem[bus.pixel_addr];
        bus.spre_pixel <= sp_mem[bus.pixel_addr];
    end

    int n_vec = 0;
    int n_err = 0;

    // Row statistics, gathered once per cycle at the falling edge.
    int cyc, wr_cnt, wr_next, ord_err, dat_err, first_wr, last_wr;
    int rd_cnt, rd_cyc, ovr_cnt, busy_at_rd;
    logic [2:0] row_en;
    logic       use_const;
    logic [9:0] const_exp;

    // Reference: each opaque layer gets a rank; the highest rank wins.
    function automatic logic [9:0] ref_pix(input logic [9:0] bg, input logic [9:0] fg,
                                           input logic [11:0] sp, input logic [2:0] en);
        int best;
        int rk;
        logic [9:0] r;
        best = 0;
        r = 10'd0;
        if (en[0] && bg[3:0] != 4'd0 && best < 2) begin best = 2; r = bg; end
        if (en[1] && fg[3:0] != 4'd0 && best < 4) begin best = 4; r = fg; end
        if (en[2] && sp[3:0] != 4'd0) begin
            rk = (sp[11:10] >= 2) ? 5 : (sp[11:10] == 1) ? 3 : 1;
            if (rk > best) begin best = rk; r = sp[9:0]; end
        end
        return r;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic clear_stats();
        cyc = 0; wr_cnt = 0; wr_next = 0; ord_err = 0; dat_err = 0;
        first_wr = -1; last_wr = -1; rd_cnt = 0; rd_cyc = -1; ovr_cnt = 0;
        busy_at_rd = -1;
    endtask

    task automatic step();
        logic [9:0] e;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (bus.rowram_wren) begin
            if (wr_cnt == 0) first_wr = cyc;
            last_wr = cyc;
            if (int'(bus.rowram_wraddr) != wr_next) ord_err++;
            e = use_const ? const_exp
                          : ref_pix(bg_mem[bus.rowram_wraddr], fg_mem[bus.rowram_wraddr],
                                    sp_mem[bus.rowram_wraddr], row_en);
            if (bus.rowram_wrdata != e) dat_err++;
            wr_next = int'(bus.rowram_wraddr) + 1;
            wr_cnt++;
        end
        if (row_done) begin
            rd_cnt++;
            rd_cyc = cyc;
            busy_at_rd = int'(busy);
        end
        if (overrun) ovr_cnt++;
    endtask

    task automatic pulse_prep();
        clear_stats();
        prep = 1'b1;
        step();
        prep = 1'b0;
    endtask

    task automatic wait_row_done();
        while (rd_cnt == 0 && cyc < 2000) step();
    endtask

    task automatic check_row(input string nm, input int exp_first);
        check({nm, ".writes"},   wr_cnt,     W);
        check({nm, ".order"},    ord_err,    0);
        check({nm, ".data"},     dat_err,    0);
        check({nm, ".first_wr"}, first_wr,   exp_first);
        check({nm, ".row_done"}, rd_cnt,     1);
        check({nm, ".rd_time"},  rd_cyc,     exp_first + W);
        check({nm, ".overrun"},  ovr_cnt,    0);
        check({nm, ".idle"},     busy_at_rd, 0);
    endtask

    task automatic set_en(input logic [2:0] en);
        {spre_en, fgte_en, bgte_en} = en;
        row_en = en;
    endtask

    task automatic fill_random();
        for (int a = 0; a < 512; a++) begin
            bg_mem[a] = {6'($urandom), 4'($urandom_range(0, 3))};
            fg_mem[a] = {6'($urandom), 4'($urandom_range(0, 3))};
            sp_mem[a] = {2'($urandom), 6'($urandom), 4'($urandom_range(0, 3))};
        end
    endtask

    typedef struct {
        logic [9:0]  bg;
        logic [9:0]  fg;
        logic [11:0] sp;
        logic [2:0]  en;    // {spr, fg, bg}
        logic        dones;
        logic [9:0]  exp;
    } vec_t;

    vec_t tbl [14];

    initial begin
        int pa0, pa_chg, wr_before, wren_after;

        tbl[0]  = '{10'h025, 10'h030, 12'h041, 3'b111, 1'b1, 10'h025};
        tbl[1]  = '{10'h011, 10'h022, 12'h033, 3'b111, 1'b1, 10'h022};
        tbl[2]  = '{10'h011, 10'h022, 12'h433, 3'b111, 1'b1, 10'h022};
        tbl[3]  = '{10'h011, 10'h022, 12'h833, 3'b111, 1'b1, 10'h033};
        tbl[4]  = '{10'h011, 10'h022, 12'hC33, 3'b111, 1'b1, 10'h033};
        tbl[5]  = '{10'h011, 10'h020, 12'h033, 3'b111, 1'b1, 10'h011};
        tbl[6]  = '{10'h011, 10'h020, 12'h433, 3'b111, 1'b1, 10'h033};
        tbl[7]  = '{10'h011, 10'h020, 12'h833, 3'b111, 1'b1, 10'h033};
        tbl[8]  = '{10'h011, 10'h020, 12'hC33, 3'b111, 1'b1, 10'h033};
        tbl[9]  = '{10'h010, 10'h020, 12'hC30, 3'b111, 1'b1, 10'h000};
        tbl[10] = '{10'h011, 10'h022, 12'hC33, 3'b000, 1'b0, 10'h000};
        tbl[11] = '{10'h011, 10'h022, 12'h433, 3'b101, 1'b1, 10'h033};
        tbl[12] = '{10'h011, 10'h022, 12'h033, 3'b100, 1'b1, 10'h033};
        tbl[13] = '{10'h011, 10'h022, 12'hC33, 3'b001, 1'b1, 10'h011};

        rst = 1'b1; prep = 1'b0;
        set_en(3'b111);
        {bgte_done, fgte_done, spre_done} = 3'b111;
        use_const = 1'b0; const_exp = '0;
        fill_random();
        clear_stats();
        repeat (3) step();
        check("reset.outputs",
              int'({bus.pixel_addr, bus.rowram_wrdata, bus.rowram_wraddr,
                    bus.rowram_wren, busy, row_done, overrun}), 0);
        rst = 1'b0;
        step();

        // Constant-layer vectors.
        use_const = 1'b1;
        for (int i = 0; i < 14; i++) begin
            for (int a = 0; a < 512; a++) begin
                bg_mem[a] = tbl[i].bg;
                fg_mem[a] = tbl[i].fg;
                sp_mem[a] = tbl[i].sp;
            end
            const_exp = tbl[i].exp;
            set_en(tbl[i].en);
            {bgte_done, fgte_done, spre_done} = {3{tbl[i].dones}};
            pulse_prep();
            wait_row_done();
            check_row($sformatf("tbl%0d", i), 4);
            step();
        end
        use_const = 1'b0;
        {bgte_done, fgte_done, spre_done} = 3'b111;

        // Random rows against the reference model.
        for (int r = 0; r < 6; r++) begin
            fill_random();
            set_en(3'($urandom_range(0, 7)));
            pulse_prep();
            wait_row_done();
            check_row($sformatf("rand%0d", r), 4);
            step();
        end

        // fgte_done rises 50 cycles after prep.
        fill_random();
        set_en(3'b111);
        fgte_done = 1'b0;
        pa0 = int'(bus.pixel_addr);
        pa_chg = 0;
        pulse_prep();
        while (cyc < 50) begin
            step();
            if (int'(bus.pixel_addr) != pa0) pa_chg++;
        end
        fgte_done = 1'b1;
        wait_row_done();
        check("late_done.addr_held", pa_chg, 0);
        check_row("late_done", 53);
        step();

        // prep again while pixel 100 is being issued.
        fill_random();
        set_en(3'b111);
        pulse_prep();
        while (int'(bus.pixel_addr) != 100 && cyc < 200) step();
        prep = 1'b1;
        step();
        prep = 1'b0;
        wr_before  = wr_cnt;
        wren_after = int'(bus.rowram_wren);
        check("overrun.pulse",       ovr_cnt,    1);
        check("overrun.no_wr",       wren_after, 0);
        check("overrun.writes_kept", wr_before,  99);
        clear_stats();
        cyc = 1;
        wait_row_done();
        check_row("overrun_row", 4);
        step();

        // prep in the same cycle as the final write.
        fill_random();
        set_en(3'b111);
        pulse_prep();
        while (!(bus.rowram_wren && int'(bus.rowram_wraddr) == W - 1) && cyc < 600) step();
        check("b2b.writes", wr_cnt, W);
        prep = 1'b1;
        step();
        prep = 1'b0;
        check("b2b.row_done", rd_cnt,  1);
        check("b2b.overrun",  ovr_cnt, 0);
        check("b2b.busy",     int'(busy), 1);
        clear_stats();
        cyc = 1;
        wait_row_done();
        check_row("b2b_row", 4);
        step();

        // Synchronous reset mid-row.
        fill_random();
        set_en(3'b111);
        pulse_prep();
        while (int'(bus.pixel_addr) != 150 && cyc < 300) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst.outputs",
              int'({bus.pixel_addr, bus.rowram_wrdata, bus.rowram_wraddr,
                    bus.rowram_wren, busy, row_done, overrun}), 0);
        clear_stats();
        repeat (10) step();
        check("midrst.no_writes", wr_cnt,     0);
        check("midrst.idle",      int'(busy), 0);
        pulse_prep();
        wait_row_done();
        check_row("after_rst", 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pixel_mixer.md
Name: pixel_mixer

Overview:
- Final composition stage of ppu_logic.
- Sits downstream of the two tile engines (bgte, fgte) and the sprite engine (spre), and upstream of row_ram_swap.
- On each row prep, waits for every enabled engine to finish its row buffer, then sweeps a shared pixel address across the row.
- Resolves layer priority and transparency per pixel, and writes the resulting palette reference into the pixel-mixer side of the row RAM.

Parameters:
- ROW_WIDTH, 320, visible pixels per row; must be ≤ 512.
- ADDR_W, 9, width of pixel/rowram address.
- PIX_W, 10, width of a layer pixel: [9:4] palette number, [3:0] colour index.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- prep  in  1  one-cycle pulse: start composing the next row (same timing as rowram_swap)
- bgte_en  in  1  background layer enable (double-buffered control reg)
- fgte_en  in  1  foreground layer enable
- spre_en  in  1  sprite layer enable
- bgte_done  in  1  level: bgte row buffer complete for current prep
- fgte_done  in  1  level: fgte row buffer complete
- spre_done  in  1  level: spre row buffer complete
- pixel_addr  out  ADDR_W  shared read address into all engine row buffers
- bgte_pixel  in  PIX_W  bgte pixel at pixel_addr, 1-cycle read latency
- fgte_pixel  in  PIX_W  fgte pixel, 1-cycle latency
- spre_pixel  in  PIX_W+2  {prio[1:0], pixel}, 1-cycle latency
- rowram_wrdata  out  PIX_W  composed pixel
- rowram_wraddr  out  ADDR_W  write address
- rowram_wren  out  1  write strobe
- busy  out  1  high in any state other than IDLE
- row_done  out  1  one-cycle pulse after the last write of a row
- overrun  out  1  one-cycle pulse when prep arrives before the current row completed

Behaviour:
- Reset:
  - state = IDLE.
  - All outputs 0, including pixel_addr, rowram_wrdata and rowram_wraddr.
  - Internal pipeline valid bits cleared.
  - A reset mid-row abandons the row; no further writes occur.
- States:
  - IDLE: on prep -> WAIT.
  - WAIT: when (bgte_done|~bgte_en) & (fgte_done|~fgte_en) & (spre_done|~spre_en) -> MIX, with the address counter at 0.
  - MIX: each cycle drive pixel_addr = counter and increment the counter; after issuing ROW_WIDTH-1 -> DRAIN.
  - DRAIN: wait until the pipeline is empty, pulse row_done -> IDLE.
- Pipeline: address issued in cycle t, engine data arrives in t+1, registered write in t+2.
  - rowram_wren = 1 with rowram_wraddr = issued address.
  - Exactly ROW_WIDTH writes per row, addresses 0..ROW_WIDTH-1 in order, with no gaps.
  - First write occurs 2 cycles after entering MIX.
  - row_done pulses the cycle after the final write.
- Transparency: a layer pixel is transparent if its colour index is 0 or its layer enable is 0.
- Priority, highest first:
  - sprite with prio ≥ 2
  - fgte
  - sprite with prio = 1
  - bgte
  - sprite with prio = 0
  - backdrop 10'd0
- The first non-transparent candidate in that order is written unchanged.
- Enables are sampled once, on the WAIT→MIX transition, and held for the row.
- prep in WAIT, MIX or DRAIN:
  - Pulse overrun.
  - Drop in-flight pipeline data; no write occurs for it.
  - Reset the counter and go to WAIT for the new row.
- prep in IDLE: normal start, no overrun.
- prep in the same cycle as the final write: the write completes, overrun is not asserted, row_done is still pulsed, and the FSM goes to WAIT.
- Done deasserting during MIX is ignored.
- All enables 0: WAIT exits immediately and ROW_WIDTH backdrop pixels are written.
- pixel_addr holds its last value when not in MIX.
- rowram_wren is 0 outside valid pipeline cycles.

Decomposition:
- ppu_pkg:
  - ROW_WIDTH default, PIX_W
  - pixel_t struct {palette[5:0], color[3:0]}
  - sprite_pixel_t {prio[1:0], pixel_t}
  - mixer_state_e {IDLE, WAIT, MIX, DRAIN}
  - SPR_PRIO_* constants
- Sub-module pixel_mix_sel: purely combinational priority/transparency resolver (three pixels + latched enables -> pixel_t), reused by verification as the reference model.

Test Plan:
- Reset held, then prep with all dones=1 and bg=10'h025, fg=10'h030, spr={2'd0,10'h041}: 320 writes of 10'h025 at addrs 0..319, first write 3 cycles after prep, row_done one cycle after addr 319.
- Priority sweep, all enabled: bg=10'h011, fg=10'h022, spr prio 0/1/2/3 with pixel 10'h033 -> writes 10'h022, 10'h022, 10'h033, 10'h033. With fg=10'h020 (transparent) -> 10'h011, 10'h033, 10'h033, 10'h033.
- All layers colour 0 or all enables 0 -> every write 10'h000; WAIT exits in 1 cycle even with dones=0.
- fgte_done delayed 50 cycles after prep: no pixel_addr change or wren until the cycle after fgte_done rises, then the normal 320-write sweep.
- prep re-pulsed at pixel 100: overrun pulse; no write for in-flight addrs 99–100; new row restarts at addr 0 and completes 320 writes with one row_done.
- Synchronous rst asserted mid-MIX for 1 cycle: the next cycle has wren=0, busy=0 and all outputs 0; the next prep produces a full clean row.
